fir_coeff_arbiter: RTL

Shares the single FIR coefficient master between `N_REQ` independent requesters, such as the slow-control register interface and the run-start coefficient loader. It arbitrates round-robin and forwards one read or write at a time over the master's 4-phase req/ack handshake. It also returns read data and a timeout error to the winning requester. It sits directly upstream of `fir_coeff_master`; its `m_*` ports connect 1:1 to that block's `req`/`wr_op`/`ack`/`coeff_wr_data`/`coeff_rd_data`.

---
 rtl/fir_coeff_pkg.sv | 18 +
 rtl/fir_coeff_arbiter_rr_pick.sv | 31 +++
 rtl/fir_coeff_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared constants, state encoding and width helper for the FIR coefficient arbiter.
package fir_coeff_pkg;

    localparam int unsigned COEFF_W = 128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_HOLD  = 3'd2,
        S_LATE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible requester after the last grant.
module rr_pick
    import fir_coeff_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned GRANT_W = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   eligible,
    input  logic [GRANT_W-1:0] last,
    output logic               valid,
    output logic [GRANT_W-1:0] index
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    always_comb begin
        valid = 1'b0;
        index = '0;
        // Rotate so bit 0 is the requester just after the last grant.
        dbl   = {eligible, eligible};
        rot   = N_REQ'(dbl >> (32'(last) + 32'd1));
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                index = GRANT_W'((32'(last) + 32'd1 + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fir_coeff_arbiter.sv
// Round-robin arbiter sharing the FIR coefficient master between N_REQ requesters.
module fir_coeff_arbiter
    import fir_coeff_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_in,
    input  logic [N_REQ-1:0]         wr_op_in,
    input  logic [COEFF_W*N_REQ-1:0] wr_data_in,
    output logic [N_REQ-1:0]         ack_out,
    output logic [N_REQ-1:0]         err_out,
    output logic [COEFF_W-1:0]       rd_data_out,
    output logic                     busy,
    output logic                     fault,
    output logic                     m_req,
    output logic                     m_wr_op,
    output logic [COEFF_W-1:0]       m_wr_data,
    input  logic                     m_ack,
    input  logic [COEFF_W-1:0]       m_rd_data
);

    localparam int unsigned GRANT_W = grant_w(N_REQ);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 m_req_q, m_req_d;
    logic                 m_wr_op_q, m_wr_op_d;
    logic [COEFF_W-1:0]   m_wr_data_q, m_wr_data_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [N_REQ-1:0]     err_q, err_d;
    logic [COEFF_W-1:0]   rd_data_q, rd_data_d;
    logic                 fault_q, fault_d;
    logic                 busy_q;

    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     grant_onehot;
    logic                 pick_valid;
    logic [GRANT_W-1:0]   pick_idx;

    assign eligible     = req_in & ~ack_q;
    assign grant_onehot = N_REQ'(1) << grant_q;

    rr_pick #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .eligible (eligible),
        .last     (last_q),
        .valid    (pick_valid),
        .index    (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        m_req_d     = m_req_q;
        m_wr_op_d   = m_wr_op_q;
        m_wr_data_d = m_wr_data_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    m_wr_op_d   = wr_op_in[pick_idx];
                    m_wr_data_d = wr_data_in[32'(pick_idx)*COEFF_W +: COEFF_W];
                    m_req_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (m_ack) begin
                    rd_data_d = m_rd_data;
                    if (req_in[grant_q]) begin
                        ack_d   = grant_onehot;
                        state_d = S_HOLD;
                    end else begin
                        // Requester gave up; finish the handshake without acking it.
                        m_req_d = 1'b0;
                        state_d = S_DRAIN;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    ack_d     = grant_onehot;
                    err_d     = grant_onehot;
                    fault_d   = 1'b1;
                    rd_data_d = '0;
                    state_d   = S_LATE;
                end
            end
            S_HOLD: begin
                if (!req_in[grant_q]) begin
                    ack_d   = '0;
                    err_d   = '0;
                    m_req_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_LATE: begin
                if (!req_in[grant_q]) begin
                    ack_d = '0;
                    err_d = '0;
                end
                if (m_ack) begin
                    m_req_d = 1'b0;
                end
                if ((ack_d == '0) && !m_req_d) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!m_ack) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                m_req_d     = 1'b0;
                m_wr_op_d   = 1'b0;
                m_wr_data_d = '0;
                ack_d       = '0;
                err_d       = '0;
                rd_data_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= GRANT_W'(N_REQ - 1);
            cnt_q       <= '0;
            m_req_q     <= 1'b0;
            m_wr_op_q   <= 1'b0;
            m_wr_data_q <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rd_data_q   <= '0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            m_req_q     <= m_req_d;
            m_wr_op_q   <= m_wr_op_d;
            m_wr_data_q <= m_wr_data_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            fault_q     <= fault_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign ack_out     = ack_q;
    assign err_out     = err_q;
    assign rd_data_out = rd_data_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign m_req       = m_req_q;
    assign m_wr_op     = m_wr_op_q;
    assign m_wr_data   = m_wr_data_q;

endmodule
